// File: rtl/countdown_pkg.sv
// ============================================================================
// countdown_pkg : shared width and controller state encoding for countdown_ctrl
// Revision      : 1.0
// ============================================================================
`default_nettype none

package countdown_pkg;

    localparam int WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : countdown_pkg

`default_nettype wire

// File: rtl/decrementer.sv
// ============================================================================
// decrementer : combinational ripple-borrow X - 1; Co[i] is the borrow out of
//               bit i, so Co[WIDTH-1] flags an underflow from zero.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module decrementer #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Co
);

    assign S[0]  = ~X[0];
    assign Co[0] = ~X[0];

    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_bit
            assign S[i]  = X[i] ^ Co[i-1];
            assign Co[i] = ~X[i] & Co[i-1];
        end
    endgenerate

endmodule : decrementer

`default_nettype wire

// File: rtl/countdown_ctrl.sv
// ============================================================================
// countdown_ctrl : loadable start/hold countdown timer built around the
//                  decrementer, with one-shot and auto-reload modes.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int WIDTH = countdown_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic             Hold,
    input  logic             Abort,
    input  logic             Mode,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Zero
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    state_t           r_state;
    logic             r_done;

    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_r_nxt;
    state_t           w_state_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_co;
    logic             w_zero;

    decrementer #(
        .WIDTH (WIDTH)
    ) u_dec (
        .X  (r_q),
        .S  (w_s),
        .Co (w_co)
    );

    // Every borrow set means every bit of Q is zero.
    assign w_zero = &w_co;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_r     <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if (Load) begin
            w_q_nxt     = D;
            w_r_nxt     = D;
            w_state_nxt = ST_IDLE;
        end else if (Abort && (r_state == ST_RUN)) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            if (Start) begin
                if (w_zero) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
        end else if (!Hold && !w_co[WIDTH-1]) begin
            // S == 0 means Q == 1: this is the terminal edge.
            if (w_s != '0) begin
                w_q_nxt = w_s;
            end else begin
                w_done_nxt = 1'b1;
                if (Mode && (r_r != '0)) begin
                    w_q_nxt = r_r;
                end else begin
                    w_q_nxt     = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    assign Q    = r_q;
    assign Busy = (r_state == ST_RUN);
    assign Done = r_done;
    assign Zero = w_zero;

endmodule : countdown_ctrl

`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
// ============================================================================
// tb_countdown_ctrl : directed scoreboard bench for countdown_ctrl
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_countdown_ctrl;
    import countdown_pkg::*;

    typedef struct {
        logic [3:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Load = 1'b0;
    logic [3:0] D = 4'd0;
    logic       Start = 1'b0;
    logic       Hold = 1'b0;
    logic       Abort = 1'b0;
    logic       Mode = 1'b0;
    logic [3:0] Q;
    logic       Busy;
    logic       Done;
    logic       Zero;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    countdown_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Load  (Load),
        .D     (D),
        .Start (Start),
        .Hold  (Hold),
        .Abort (Abort),
        .Mode  (Mode),
        .Q     (Q),
        .Busy  (Busy),
        .Done  (Done),
        .Zero  (Zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input exp_t e);
        checks++;
        if (Q !== e.q || Busy !== e.busy || Done !== e.done || Zero !== (e.q == 4'd0)) begin
            failures++;
            $display("FAIL %s: got Q=%0d Busy=%0b Done=%0b Zero=%0b, expected Q=%0d Busy=%0b Done=%0b Zero=%0b",
                     nm, Q, Busy, Done, Zero, e.q, e.busy, e.done, (e.q == 4'd0));
        end
    endtask

    // Monitor: compares the DUT outputs after every edge that has an expectation queued.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("cycle", e);
        end
    end

    // Decrementer must never borrow out of its top bit when a count edge is taken.
    always @(posedge clk) begin
        if (rst_n && dut.r_state == ST_RUN && !Load && !Abort && !Hold) begin
            checks++;
            if (dut.w_co[3] !== 1'b0) begin
                failures++;
                $display("FAIL underflow: got Co[3]=%0b, expected 0 at Q=%0d", dut.w_co[3], Q);
            end
        end
    end

    task automatic cyc(input logic ld, input logic [3:0] d, input logic st, input logic hd,
                       input logic ab, input logic md,
                       input logic [3:0] eq, input logic eb, input logic ed);
        exp_t e;
        Load = ld; D = d; Start = st; Hold = hd; Abort = ab; Mode = md;
        e.q = eq; e.busy = eb; e.done = ed;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic md, input logic [3:0] eq, input logic eb, input logic ed);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, md, eq, eb, ed);
    endtask

    initial begin
        exp_t rv;
        rv.q = 4'd0; rv.busy = 1'b0; rv.done = 1'b0;
        #12;
        check("reset", rv);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        // One-shot from 3
        cyc(1, 4'd3, 0, 0, 0, 0, 4'd3, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 0, 4'd3, 1, 0);
        idle(0, 4'd2, 1, 0);
        idle(0, 4'd1, 1, 0);
        idle(0, 4'd0, 0, 1);
        idle(0, 4'd0, 0, 0);

        // Auto-reload from 5, then Abort at Q=4
        cyc(1, 4'd5, 0, 0, 0, 1, 4'd5, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 1, 4'd5, 1, 0);
        idle(1, 4'd4, 1, 0);
        idle(1, 4'd3, 1, 0);
        idle(1, 4'd2, 1, 0);
        idle(1, 4'd1, 1, 0);
        idle(1, 4'd5, 1, 1);
        idle(1, 4'd4, 1, 0);
        idle(1, 4'd3, 1, 0);
        idle(1, 4'd2, 1, 0);
        idle(1, 4'd1, 1, 0);
        idle(1, 4'd5, 1, 1);
        idle(1, 4'd4, 1, 0);
        cyc(0, 4'd0, 0, 0, 1, 1, 4'd4, 0, 0);
        idle(1, 4'd4, 0, 0);

        // Hold three cycles at Q=6
        cyc(1, 4'd8, 0, 0, 0, 0, 4'd8, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 0, 4'd8, 1, 0);
        idle(0, 4'd7, 1, 0);
        idle(0, 4'd6, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 4'd0, 0, 1, 0, 0, 4'd6, 1, 0);
        idle(0, 4'd5, 1, 0);
        idle(0, 4'd4, 1, 0);
        idle(0, 4'd3, 1, 0);
        idle(0, 4'd2, 1, 0);
        idle(0, 4'd1, 1, 0);
        idle(0, 4'd0, 0, 1);

        // Load with simultaneous Start mid-run
        cyc(1, 4'd10, 0, 0, 0, 0, 4'd10, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 0, 4'd10, 1, 0);
        idle(0, 4'd9, 1, 0);
        idle(0, 4'd8, 1, 0);
        idle(0, 4'd7, 1, 0);
        cyc(1, 4'd2, 1, 0, 0, 0, 4'd2, 0, 0);
        idle(0, 4'd2, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 0, 4'd2, 1, 0);
        idle(0, 4'd1, 1, 0);
        idle(0, 4'd0, 0, 1);

        // Start with Q=0
        cyc(0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 1);
        idle(0, 4'd0, 0, 0);

        // Auto-reload with R=1: Done every cycle
        cyc(1, 4'd1, 0, 0, 0, 1, 4'd1, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 1, 4'd1, 1, 0);
        for (int i = 0; i < 3; i++) idle(1, 4'd1, 1, 1);
        cyc(0, 4'd0, 0, 0, 1, 1, 4'd1, 0, 0);

        // Asynchronous reset mid-run at Q=3
        cyc(1, 4'd5, 0, 0, 0, 0, 4'd5, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 0, 4'd5, 1, 0);
        idle(0, 4'd4, 1, 0);
        idle(0, 4'd3, 1, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset", rv);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(0, 4'd0, 0, 0);
        idle(0, 4'd0, 0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout: got no completion by 50000, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_countdown_ctrl

`default_nettype wire

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequential controller that drives the team's combinational 4-bit `decrementer` and registers its result. It turns the single-step `X - 1` datapath into a loadable, start/hold-controlled countdown timer with one-shot and auto-reload modes. It sits directly upstream of `decrementer`:
- it feeds `X` from its count register;
- it captures `S` back on every active count edge;
- it emits a one-cycle `Done` pulse for downstream control.

## Interface
Parameters:
- `WIDTH`, 4, count width. Must equal the `decrementer` width; only 4 is supported.

Ports:
- `clk`  in  1  rising-edge clock, single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `Load`  in  1  capture `D` into count and reload registers
- `D`  in  WIDTH  load value
- `Start`  in  1  begin counting from current `Q`
- `Hold`  in  1  freeze count while running
- `Abort`  in  1  stop counting and return to IDLE, keeping `Q`
- `Mode`  in  1  0 = one-shot, 1 = auto-reload
- `Q`  out  WIDTH  current count (registered)
- `Busy`  out  1  high while in RUN
- `Done`  out  1  registered one-cycle terminal pulse
- `Zero`  out  1  `Q == 0`, combinational from the register

## Operation
- Reset (async, `rst_n`=0):
  - `Q`=0, reload register `R`=0, state=IDLE;
  - `Busy`=0, `Done`=0, `Zero`=1.
- States: IDLE, RUN.
- Priority, evaluated every edge: `Load` > `Abort` > `Start` > count.
- `Load` in any state:
  - `Q`<=`D`, `R`<=`D`, state<=IDLE, `Done`<=0;
  - a simultaneous `Start` is ignored.
- `Abort` in RUN: state<=IDLE, `Q` held, no `Done`. In IDLE it has no effect.
- `Start` in IDLE:
  - if `Q`!=0, state<=RUN with `Q` unchanged;
  - if `Q`==0, `Done`<=1 for one cycle and state stays IDLE.
- `Start` in RUN is ignored.
- RUN with `Hold`=1: `Q` and state frozen, `Done`<=0.
- RUN with `Hold`=0 and `Q`>1: `Q`<=`S` (that is, `Q`-1).
- RUN with `Hold`=0 and `Q`==1 (terminal edge):
  - `Done`<=1;
  - `Mode`=0: `Q`<=0, state<=IDLE;
  - `Mode`=1: `Q`<=`R`, stay in RUN. If `R`==0, `Q`<=0 and state<=IDLE instead.
- `Mode` is sampled at the terminal edge only.
- Underflow never occurs: RUN with `Q`==0 is unreachable. `decrementer` borrow-out `Co[WIDTH-1]` must be 0 whenever a count edge is taken; the bench asserts this.
- `Done` is 0 in every cycle not stated above.

## Timing
- `Load`/`Start` are sampled at edge k. The first decrement happens at edge k+1 if `Start` was accepted at edge k.
- One-shot latency: from `Start` accepted to `Done` high is exactly `Q0` edges. `Done` is high during the cycle in which `Q` first reads 0.
- Auto-reload period: `R` cycles between `Done` pulses when `Hold` is never asserted. `R`=1 gives `Done` high every cycle.
- `Hold` cycles extend the period one-for-one.
- `Busy` is registered state: it rises one cycle after `Start` and falls in the same cycle `Done` is high (one-shot).
- Reset asserted mid-count: all outputs go to reset values immediately, with no `Done`. After release, the block waits for `Load`/`Start`.

## Structure
- Shared package `countdown_pkg`:
  - state localparams `ST_IDLE`=1'b0, `ST_RUN`=1'b1;
  - `WIDTH` default 4.
- One sub-module instance: the existing `decrementer` (`X`=`Q`, `S` → next-count mux, `Co` → underflow check).
- Registers: `Q`, `R`, state, `Done`.

## Test plan
- Reset, then `Load` `D`=3, then `Start`, `Mode`=0 → `Q` reads 3,3,2,1,0. `Done` is high only in the Q=0 cycle; `Busy` is high for 3 cycles; the block ends in IDLE.
- `Load` 5, `Mode`=1, `Start`, run 12 cycles → `Q` sequence 5,5,4,3,2,1,5,4,…, with `Done` every 5 cycles and `Busy` staying 1.
- `Load` 8, `Start`, `Hold`=1 for 3 cycles at `Q`=6 → `Q` stays 6 for 3 cycles. `Done` arrives 3 cycles later than the unheld case (11 edges after `Start`).
- `Load` 10, `Start`; at `Q`=7 assert `Load` `D`=2 together with `Start` → `Q`=2, IDLE, `Busy`=0, no `Done`. A following `Start` gives `Done` 2 edges later.
- `Start` with `Q`=0 → one-cycle `Done`, `Busy` stays 0. `Abort` at `Q`=4 in RUN → IDLE, `Q` holds 4, no `Done`.
- Assert `rst_n`=0 asynchronously mid-RUN at `Q`=3 → `Q`=0, `Busy`=0, `Done`=0, `Zero`=1 before the next clock edge.
